// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential divider.
package div_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFix,
        StDone
    } divState_e;

    // Width of the iteration counter for a given operand width.
    function automatic int unsigned cntWidth(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference when it does not go negative.
module div_step #(
    parameter int unsigned WWidth = 32
) (
    input  logic [WWidth-1:0] partRem,
    input  logic              nextBit,
    input  logic [WWidth:0]   divisorMag,
    output logic [WWidth-1:0] newRem,
    output logic              quoBit
);

    logic [WWidth:0] shifted;

    // Partial remainder is always below the divisor, so the result fits WWidth bits.
    always_comb begin
        shifted = {partRem, nextBit};
        quoBit  = (shifted >= divisorMag);
        newRem  = WWidth'(quoBit ? shifted - divisorMag : shifted);
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative signed divider (restoring, one quotient bit per clock, then sign fix-up).
// Optional build macro UNSIGNED_DIV_EN adds the is_signed input for unsigned divides.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WWidth = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
`ifdef UNSIGNED_DIV_EN
    input  logic              is_signed,
`endif
    input  logic [WWidth-1:0] dividend,
    input  logic [WWidth-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [WWidth-1:0] quotient,
    output logic [WWidth-1:0] remainder,
    output logic              div_by_zero,
    output logic              overflow
);

    localparam int unsigned       CntW   = cntWidth(WWidth);
    localparam logic [WWidth-1:0] MinInt = {1'b1, {(WWidth-1){1'b0}}};

    divState_e         stateQ, stateD;
    logic [CntW-1:0]   cntQ;
    logic [WWidth-1:0] dvdQ;      // dividend magnitude, consumed MSB-first
    logic [WWidth:0]   dsrQ;      // divisor magnitude, one spare bit for |MIN_INT|
    logic [WWidth-1:0] remQ;
    logic [WWidth-1:0] quoQ;
    logic              quoNegQ;
    logic              remNegQ;
    logic [WWidth-1:0] quotientQ;
    logic [WWidth-1:0] remainderQ;
    logic              dbzQ;
    logic              ovfQ;

    logic              signedOp;
    logic              dvdNeg;
    logic              dsrNeg;
    logic [WWidth-1:0] stepRem;
    logic              stepBit;

`ifdef UNSIGNED_DIV_EN
    assign signedOp = is_signed;
`else
    assign signedOp = 1'b1;
`endif
    assign dvdNeg = signedOp & dividend[WWidth-1];
    assign dsrNeg = signedOp & divisor[WWidth-1];

    div_step #(
        .WWidth (WWidth)
    ) uStep (
        .partRem    (remQ),
        .nextBit    (dvdQ[WWidth-1]),
        .divisorMag (dsrQ),
        .newRem     (stepRem),
        .quoBit     (stepBit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= StIdle;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state; divide-by-zero skips the iterations but still passes through FIX
    // so its results are registered before the done pulse.
    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StIdle:  if (start) stateD = (divisor == '0) ? StFix : StRun;
            StRun:   if (cntQ == '0) stateD = StFix;
            StFix:   stateD = StDone;
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    // Operand capture, restoring iterations and result fix-up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cntQ       <= '0;
            dvdQ       <= '0;
            dsrQ       <= '0;
            remQ       <= '0;
            quoQ       <= '0;
            quoNegQ    <= 1'b0;
            remNegQ    <= 1'b0;
            quotientQ  <= '0;
            remainderQ <= '0;
            dbzQ       <= 1'b0;
            ovfQ       <= 1'b0;
        end else begin
            case (stateQ)
                StIdle: begin
                    if (start) begin
                        dvdQ    <= dvdNeg ? -dividend : dividend;
                        dsrQ    <= {1'b0, (dsrNeg ? -divisor : divisor)};
                        remQ    <= '0;
                        quoQ    <= '0;
                        quoNegQ <= dvdNeg ^ dsrNeg;
                        remNegQ <= dvdNeg;
                        dbzQ    <= (divisor == '0);
                        ovfQ    <= signedOp && (dividend == MinInt) && (divisor == '1);
                        cntQ    <= CntW'(WWidth - 1);
                    end
                end
                StRun: begin
                    remQ <= stepRem;
                    quoQ <= {quoQ[WWidth-2:0], stepBit};
                    dvdQ <= dvdQ << 1;
                    cntQ <= cntQ - CntW'(1);
                end
                StFix: begin
                    if (dbzQ) begin
                        // dvdQ was never shifted, so re-signing it restores the dividend.
                        quotientQ  <= '1;
                        remainderQ <= remNegQ ? -dvdQ : dvdQ;
                    end else begin
                        quotientQ  <= quoNegQ ? -quoQ : quoQ;
                        remainderQ <= remNegQ ? -remQ : remQ;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and result outputs.
    always_comb begin
        busy        = (stateQ == StRun) || (stateQ == StFix);
        done        = (stateQ == StDone);
        quotient    = quotientQ;
        remainder   = remainderQ;
        div_by_zero = dbzQ;
        overflow    = ovfQ;
    end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference.
// Build with UNSIGNED_DIV_EN defined to exercise the unsigned mode as well.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         isSigned = 1'b1;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int nChecks = 0;
    int nFails  = 0;

    seq_divider #(
        .WWidth (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
`ifdef UNSIGNED_DIV_EN
        .is_signed   (isSigned),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Reference: truncating division, remainder follows the dividend.
    function automatic void refDiv(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output bit dz, output bit ov);
        longint sa;
        longint sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Present operands and start before an edge; returns just after the accept edge.
    task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        isSigned = sgn;
        start    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Wait for done, counting edges after the accept edge and cycles with busy high.
    task automatic waitDone(input int glitchAt, output int edges, output int busyHigh);
        edges    = 0;
        busyHigh = busy ? 1 : 0;
        while (!done && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busyHigh++;
            if (edges == glitchAt) begin
                start    = 1'b1;
                dividend = 32'd999;
                divisor  = 32'd3;
            end else if (edges == glitchAt + 1) begin
                start = 1'b0;
            end
        end
        check("done_seen", done, 1);
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit sgn, input int edges, input int busyHigh);
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           dz;
        bit           ov;
        refDiv(a, b, sgn, q, r, dz, ov);
        check({tag, "_latency"}, edges, (b == 0) ? 1 : W + 1);
        check({tag, "_busy"}, busyHigh, (b == 0) ? 1 : W + 1);
        check({tag, "_q"}, quotient, q);
        check({tag, "_r"}, remainder, r);
        check({tag, "_dbz"}, div_by_zero, dz);
        check({tag, "_ovf"}, overflow, ov);
        if (!dz) check({tag, "_invariant"}, a, W'(quotient * b + remainder));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, done, 0);
        check({tag, "_hold"}, quotient, q);
    endtask

    task automatic doOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit sgn, input int glitchAt);
        int edges;
        int busyHigh;
        startOp(a, b, sgn);
        start = 1'b0;
        waitDone(glitchAt, edges, busyHigh);
        start = 1'b0;
        checkResult(tag, a, b, sgn, edges, busyHigh);
    endtask

    function automatic logic [W-1:0] randOperand(input bit allowZero);
        logic [W-1:0] v;
        case ($urandom_range(0, 6))
            0: v = W'($urandom_range(0, 20));
            1: v = -W'($urandom_range(1, 20));
            2: v = 32'h8000_0000;
            3: v = 32'hFFFF_FFFF;
            4: v = allowZero ? '0 : 32'd1;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int edges;
        int busyHigh;
        int doneSeen;
        bit sgn;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        doOp("p100_p7", 32'd100, 32'd7, 1'b1, -1);
        doOp("n100_p7", -32'd100, 32'd7, 1'b1, -1);
        doOp("p100_n7", 32'd100, -32'd7, 1'b1, -1);
        doOp("n100_n7", -32'd100, -32'd7, 1'b1, -1);
        doOp("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
        doOp("five_zero", 32'd5, 32'd0, 1'b1, -1);
        doOp("nfive_zero", -32'd5, 32'd0, 1'b1, -1);
        doOp("min_p1", 32'h8000_0000, 32'd1, 1'b1, -1);
        doOp("min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, -1);

        // start re-pulsed with new operands mid-operation is ignored.
        doOp("glitch", 32'd100, 32'd7, 1'b1, 10);

        // start held through DONE: next operation accepted on the IDLE edge.
        startOp(32'd100, 32'd7, 1'b1);
        waitDone(-1, edges, busyHigh);
        check("held_a_q", quotient, 14);
        check("held_a_r", remainder, 2);
        dividend = 32'd1000;
        divisor  = -32'd9;
        @(posedge clk);
        #1;
        check("held_done_edge_busy", busy, 0);
        check("held_done_edge_done", done, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(-1, edges, busyHigh);
        checkResult("held_b", 32'd1000, -32'd9, 1'b1, edges, busyHigh);

        // Asynchronous reset mid-operation.
        startOp(32'd77, 32'd5, 1'b1);
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_q", quotient, 0);
        check("midrst_r", remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) doneSeen++;
        end
        check("midrst_no_done", doneSeen, 0);
        doOp("after_rst", 32'd100, 32'd7, 1'b1, -1);

`ifdef UNSIGNED_DIV_EN
        doOp("u_ffff_2", 32'hFFFF_FFFF, 32'd2, 1'b0, -1);
        doOp("u_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1);
        doOp("u_zero", 32'hFFFF_FFF0, 32'd0, 1'b0, -1);
`endif

        // Randomized run against the reference model.
        for (int i = 0; i < 400; i++) begin
`ifdef UNSIGNED_DIV_EN
            sgn = 1'($urandom_range(0, 1));
`else
            sgn = 1'b1;
`endif
            doOp("rand", randOperand(1'b1), randOperand(($urandom_range(0, 7) == 0)), sgn, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
